tap_controller: RTL

IEEE 1149.1-style TAP controller that sequences the JTAG instruction register and the test data register from TMS. It runs the 16-state TAP state machine and decodes the active instruction into a data-register select. It owns the 1-bit bypass register and the TDO output multiplexer. It sits between the chip-level JTAG pins and the INSTRUCTION_REGISTER / DATA_REGISTER blocks; their CAPTURE/SHIFT/UPDATE and TDR_SELECT inputs are driven only from here.

---
 rtl/tap_pkg.sv | 52 +++++
 rtl/tap_controller_if.sv | 33 +++
 rtl/tap_fsm.sv | 42 ++++
 rtl/tap_controller.sv | 104 ++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state codes, default opcodes and the
// next-state rule used by tap_fsm.
package tap_pkg;

   typedef enum logic [3:0] {
      EX2_DR   = 4'h0,
      EX1_DR   = 4'h1,
      SH_DR    = 4'h2,
      PAUSE_DR = 4'h3,
      SEL_IR   = 4'h4,
      UPD_DR   = 4'h5,
      CAP_DR   = 4'h6,
      SEL_DR   = 4'h7,
      EX2_IR   = 4'h8,
      EX1_IR   = 4'h9,
      SH_IR    = 4'hA,
      PAUSE_IR = 4'hB,
      RTI      = 4'hC,
      UPD_IR   = 4'hD,
      CAP_IR   = 4'hE,
      TLR      = 4'hF
   } tap_state_e;

   localparam int                       DEF_IR_LENGTH     = 5;
   localparam logic [DEF_IR_LENGTH-1:0] DEF_DR_OPCODE     = 5'b00010;
   localparam logic [DEF_IR_LENGTH-1:0] DEF_BYPASS_OPCODE = '1;

   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_state_e n;
      case (s)
         TLR:      n = tms ? TLR      : RTI;
         RTI:      n = tms ? SEL_DR   : RTI;
         SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   n = tms ? EX1_DR   : SH_DR;
         SH_DR:    n = tms ? EX1_DR   : SH_DR;
         EX1_DR:   n = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: n = tms ? EX2_DR   : PAUSE_DR;
         EX2_DR:   n = tms ? UPD_DR   : SH_DR;
         UPD_DR:   n = tms ? SEL_DR   : RTI;
         SEL_IR:   n = tms ? TLR      : CAP_IR;
         CAP_IR:   n = tms ? EX1_IR   : SH_IR;
         SH_IR:    n = tms ? EX1_IR   : SH_IR;
         EX1_IR:   n = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: n = tms ? EX2_IR   : PAUSE_IR;
         EX2_IR:   n = tms ? UPD_IR   : SH_IR;
         UPD_IR:   n = tms ? SEL_DR   : RTI;
         default:  n = TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tap_controller_if.sv
// JTAG pin and register-block signals of the TAP controller; master is the
// controller's view, slave the pins/register-block side.
interface tap_controller_if #(
   parameter int IR_LENGTH = tap_pkg::DEF_IR_LENGTH
);
   logic                 TMS;
   logic                 TDI;
   logic [IR_LENGTH-1:0] IR_IN;
   logic                 IR_TDO;
   logic                 DR_TDO;
   logic [3:0]           TAP_STATE;
   logic                 CAPTURE_IR;
   logic                 SHIFT_IR;
   logic                 UPDATE_IR;
   logic                 CAPTURE_DR;
   logic                 SHIFT_DR;
   logic                 UPDATE_DR;
   logic                 TDR_SELECT;
   logic                 TDO;
   logic                 TDO_EN;

   modport master (
      input  TMS, TDI, IR_IN, IR_TDO, DR_TDO,
      output TAP_STATE, CAPTURE_IR, SHIFT_IR, UPDATE_IR,
             CAPTURE_DR, SHIFT_DR, UPDATE_DR, TDR_SELECT, TDO, TDO_EN
   );

   modport slave (
      output TMS, TDI, IR_IN, IR_TDO, DR_TDO,
      input  TAP_STATE, CAPTURE_IR, SHIFT_IR, UPDATE_IR,
             CAPTURE_DR, SHIFT_DR, UPDATE_DR, TDR_SELECT, TDO, TDO_EN
   );
endinterface

// File: rtl/tap_fsm.sv
// 16-state TAP state machine; strobes are registered from the next state so
// they are exact Moore decodes of the state register and clear with it.
module tap_fsm
   import tap_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tms,
   output tap_state_e state,
   output logic       cap_ir,
   output logic       sh_ir,
   output logic       upd_ir,
   output logic       cap_dr,
   output logic       sh_dr,
   output logic       upd_dr
);

   tap_state_e nxt;

   assign nxt = tap_next(state, tms);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= TLR;
         cap_ir <= 1'b0;
         sh_ir  <= 1'b0;
         upd_ir <= 1'b0;
         cap_dr <= 1'b0;
         sh_dr  <= 1'b0;
         upd_dr <= 1'b0;
      end else begin
         state  <= nxt;
         cap_ir <= (nxt == CAP_IR);
         sh_ir  <= (nxt == SH_IR);
         upd_ir <= (nxt == UPD_IR);
         cap_dr <= (nxt == CAP_DR);
         sh_dr  <= (nxt == SH_DR);
         upd_dr <= (nxt == UPD_DR);
      end
   end

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: FSM, instruction decode, bypass bit and falling-edge TDO.
// Build option TAP_BYPASS_EN adds the bypass register and instruction decode.
module tap_controller
   import tap_pkg::*;
#(
   parameter int                   IR_LENGTH     = DEF_IR_LENGTH,
   parameter logic [IR_LENGTH-1:0] DR_OPCODE     = IR_LENGTH'(DEF_DR_OPCODE)
`ifdef TAP_BYPASS_EN
   ,
   parameter logic [IR_LENGTH-1:0] BYPASS_OPCODE = {IR_LENGTH{1'b1}}
`endif
) (
   input  logic             TCK,
   input  logic             TRST,
   tap_controller_if.master jtag
);

   tap_state_e state;
   logic       cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr;
   logic       tdr_select;
   logic       dr_src;
   logic       tdo_p1, tdo_en_p1;

   tap_fsm u_fsm (
      .clk    (TCK),
      .rst    (TRST),
      .tms    (jtag.TMS),
      .state  (state),
      .cap_ir (cap_ir),
      .sh_ir  (sh_ir),
      .upd_ir (upd_ir),
      .cap_dr (cap_dr),
      .sh_dr  (sh_dr),
      .upd_dr (upd_dr)
   );

`ifdef TAP_BYPASS_EN
   logic                 ir_valid;
   logic                 bypass_q;
   logic [IR_LENGTH-1:0] instr;

   // IR_IN comes from an unreset update stage: trust it only after an UPD_IR
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST)
         ir_valid <= 1'b0;
      else if (state == TLR)
         ir_valid <= 1'b0;
      else if (state == UPD_IR)
         ir_valid <= 1'b1;
   end

   // the TLR term covers the first TLR cycle before the flag has cleared
   assign instr      = (ir_valid && (state != TLR)) ? jtag.IR_IN : BYPASS_OPCODE;
   assign tdr_select = (instr == DR_OPCODE);

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST)
         bypass_q <= 1'b0;
      else if (!tdr_select) begin
         if (state == CAP_DR)
            bypass_q <= 1'b0;
         else if (state == SH_DR)
            bypass_q <= jtag.TDI;
      end
   end

   assign dr_src = tdr_select ? jtag.DR_TDO : bypass_q;
`else
   logic unused_pins;

   assign tdr_select  = 1'b1;
   assign dr_src      = jtag.DR_TDO;
   assign unused_pins = ^{jtag.TDI, jtag.IR_IN, DR_OPCODE};
`endif

   // TDO retiming stage: launched on the falling edge
   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         tdo_p1    <= 1'b0;
         tdo_en_p1 <= 1'b0;
      end else if (state == SH_IR) begin
         tdo_p1    <= jtag.IR_TDO;
         tdo_en_p1 <= 1'b1;
      end else if (state == SH_DR) begin
         tdo_p1    <= dr_src;
         tdo_en_p1 <= 1'b1;
      end else begin
         tdo_p1    <= 1'b0;
         tdo_en_p1 <= 1'b0;
      end
   end

   assign jtag.TAP_STATE  = state;
   assign jtag.CAPTURE_IR = cap_ir;
   assign jtag.SHIFT_IR   = sh_ir;
   assign jtag.UPDATE_IR  = upd_ir;
   assign jtag.CAPTURE_DR = cap_dr;
   assign jtag.SHIFT_DR   = sh_dr;
   assign jtag.UPDATE_DR  = upd_dr;
   assign jtag.TDR_SELECT = tdr_select;
   assign jtag.TDO        = tdo_p1;
   assign jtag.TDO_EN     = tdo_en_p1;

endmodule
